note_player: RTL
================

Name: note_player

Overview:
- Sits directly downstream of song_reader.
- Accepts one note at a time (note, duration, new_note strobe) and generates a phase-accumulator stream at the pitch of that note.
- Counts duration in beat strobes, then pulses note_done back to song_reader so it advances to the next note.
- The phase output feeds the sine lookup / codec stage.

Parameters:
- PHASE_W, 22, phase accumulator width; full scale is one waveform period.
- NOTE_W, 6, note code width (0 = rest, 1..63 = semitones, 49 = A4 440 Hz).
- DUR_W, 6, duration width in beats.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- play  input  1  level; 0 freezes the duration count and the phase
- new_note  input  1  one-cycle strobe; note/duration are valid this cycle
- note  input  NOTE_W  note code to load
- duration  input  DUR_W  note length in beats
- beat  input  1  one-cycle tempo strobe (48 Hz nominal)
- sample_tick  input  1  one-cycle sample-rate strobe (48 kHz nominal)
- note_done  output  1  one-cycle pulse when the loaded note's beats have elapsed
- busy  output  1  high while a note is loaded and not yet done
- phase  output  PHASE_W  current phase accumulator value
- sample_valid  output  1  one-cycle pulse, the cycle after a phase update

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; step, beat counter and phase cleared.
- State machine has three states:
  - IDLE: waiting for new_note.
  - PLAYING: note loaded, counting beats.
  - DONE: one cycle; asserts note_done.
- IDLE -> PLAYING on new_note (the play level does not gate loading).
- On load:
  - Latch step = note_step_rom(note) and beats_left = duration.
  - Reset phase to 0 on the next edge.
  - busy goes high on the cycle after the strobe.
- PLAYING with play=1:
  - Each beat decrements beats_left.
  - When a beat arrives with beats_left==1, go to DONE.
- duration==0: go directly PLAYING -> DONE on the first cycle after the load; no beats consumed.
- DONE: note_done=1 for exactly one cycle, busy=0, then go to IDLE. Phase holds its last value.
- PLAYING with play=0: beat and sample_tick are ignored; beats_left and phase hold; sample_valid stays 0.
- Phase update, only in PLAYING with play=1:
  - On sample_tick, phase <= phase + step, wrapping modulo 2^PHASE_W.
  - sample_valid pulses on the following cycle.
- Rest (note==0): step=0, so phase stays 0; beats are still counted normally.
- new_note while PLAYING: the new note reloads immediately (restart). No note_done is issued for the aborted note.
- new_note in the same cycle as the final beat: the load wins; no note_done is issued; the new note starts.
- new_note while in DONE: note_done still pulses, and the note is loaded (DONE -> PLAYING).
- Reset mid-note: immediate return to IDLE; no note_done.
- Step ROM contents:
  - step(n) = round(440 * 2^((n-49)/12) * 2^PHASE_W / 48000), zero-extended to PHASE_W.
  - step(49) = 38448; step(0) = 0.

Decomposition:
- Shared package music_pkg holds:
  - NOTE_W, DUR_W, PHASE_W
  - SAMPLE_RATE_HZ = 48000
  - state enum {IDLE, PLAYING, DONE}
- One sub-module: note_step_rom. It is combinational, NOTE_W in, PHASE_W out, 64 entries, with entry 0 = 0.
- The duration counter and accumulator stay inline.

Test Plan:
- Reset held 4 cycles, then released -> note_done=0, busy=0, phase=0, sample_valid=0; IDLE.
- new_note with note=49, duration=3, play=1, 5 sample_ticks, 3 beats -> busy=1 from the next cycle; phase=192240 after 5 ticks; note_done pulses once, the cycle after the 3rd beat; busy=0 after.
- Same load, then play=0 for 2 beats and 10 sample_ticks, then play=1 -> phase and beats_left frozen; note_done only after 3 beats counted with play=1.
- note=0, duration=2 -> phase stays 0 throughout; note_done after 2 beats.
- Load note=49, duration=2; at beat 2, simultaneously new_note with note=61, duration=1 -> no note_done; step becomes 76896; note_done after one more beat.
- duration=0 load -> note_done asserted 2 cycles after the strobe; async reset asserted mid-note (duration=5, beat 2) -> outputs 0 immediately; no note_done.

Source files
------------

// File: rtl/music_pkg.sv
// Shared widths, rates and state encoding for the note playback path.
package music_pkg;

  localparam int unsigned PHASE_W        = 22;
  localparam int unsigned NOTE_W         = 6;
  localparam int unsigned DUR_W          = 6;
  localparam int unsigned SAMPLE_RATE_HZ = 48000;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    DONE
  } state_e;

endpackage

// File: rtl/note_step_rom.sv
// Note code to phase increment: round(440 * 2^((n-49)/12) * 2^PHASE_W / SAMPLE_RATE_HZ).
module note_step_rom
  import music_pkg::*;
(
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);

  always_comb begin
    step = '0;
    case (note)
      6'd0:  step = 22'd0;
      6'd1:  step = 22'd2403;  6'd2:  step = 22'd2546;  6'd3:  step = 22'd2697;
      6'd4:  step = 22'd2858;  6'd5:  step = 22'd3028;  6'd6:  step = 22'd3208;
      6'd7:  step = 22'd3398;  6'd8:  step = 22'd3600;  6'd9:  step = 22'd3815;
      6'd10: step = 22'd4041;  6'd11: step = 22'd4282;  6'd12: step = 22'd4536;
      6'd13: step = 22'd4806;  6'd14: step = 22'd5092;  6'd15: step = 22'd5395;
      6'd16: step = 22'd5715;  6'd17: step = 22'd6055;  6'd18: step = 22'd6415;
      6'd19: step = 22'd6797;  6'd20: step = 22'd7201;  6'd21: step = 22'd7629;
      6'd22: step = 22'd8083;  6'd23: step = 22'd8563;  6'd24: step = 22'd9072;
      6'd25: step = 22'd9612;  6'd26: step = 22'd10184; 6'd27: step = 22'd10789;
      6'd28: step = 22'd11431; 6'd29: step = 22'd12110; 6'd30: step = 22'd12830;
      6'd31: step = 22'd13593; 6'd32: step = 22'd14402; 6'd33: step = 22'd15258;
      6'd34: step = 22'd16165; 6'd35: step = 22'd17127; 6'd36: step = 22'd18145;
      6'd37: step = 22'd19224; 6'd38: step = 22'd20367; 6'd39: step = 22'd21578;
      6'd40: step = 22'd22861; 6'd41: step = 22'd24221; 6'd42: step = 22'd25661;
      6'd43: step = 22'd27187; 6'd44: step = 22'd28803; 6'd45: step = 22'd30516;
      6'd46: step = 22'd32331; 6'd47: step = 22'd34253; 6'd48: step = 22'd36290;
      6'd49: step = 22'd38448; 6'd50: step = 22'd40734; 6'd51: step = 22'd43156;
      6'd52: step = 22'd45722; 6'd53: step = 22'd48441; 6'd54: step = 22'd51322;
      6'd55: step = 22'd54373; 6'd56: step = 22'd57607; 6'd57: step = 22'd61032;
      6'd58: step = 22'd64661; 6'd59: step = 22'd68506; 6'd60: step = 22'd72580;
      6'd61: step = 22'd76896; 6'd62: step = 22'd81468; 6'd63: step = 22'd86312;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: phase accumulator at the note's pitch, beat-counted length.
module note_player
  import music_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               new_note,
  input  logic [NOTE_W-1:0]  note,
  input  logic [DUR_W-1:0]   duration,
  input  logic               beat,
  input  logic               sample_tick,
  output logic               note_done,
  output logic               busy,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_valid
);

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  step_q, step_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  rom_step;
  logic [DUR_W-1:0]    beats_q, beats_d;
  logic                sample_valid_q, sample_valid_d;
  logic                advance;

  note_step_rom u_step_rom (
    .note (note),
    .step (rom_step)
  );

  assign advance = (state_q == PLAYING) && play;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A load always wins, so a final beat coinciding with new_note never reaches DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_note) state_d = PLAYING;
      PLAYING: begin
        if (new_note)                                        state_d = PLAYING;
        else if (beats_q == '0)                              state_d = DONE;
        else if (advance && beat && beats_q == DUR_W'(1))    state_d = DONE;
      end
      DONE:    state_d = new_note ? PLAYING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == PLAYING);
    note_done = (state_q == DONE);
  end

  always_comb begin
    step_d         = step_q;
    beats_d        = beats_q;
    phase_d        = phase_q;
    sample_valid_d = 1'b0;
    if (new_note) begin
      step_d  = rom_step;
      beats_d = duration;
      phase_d = '0;
    end else if (advance) begin
      if (beat && beats_q != '0) beats_d = beats_q - DUR_W'(1);
      if (sample_tick) begin
        phase_d        = phase_q + step_q;
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q         <= '0;
      beats_q        <= '0;
      phase_q        <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      step_q         <= step_d;
      beats_q        <= beats_d;
      phase_q        <= phase_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign phase        = phase_q;
  assign sample_valid = sample_valid_q;

endmodule
